// File: rtl/decomp_layer_pkg.sv
// Shared definitions for the decompression (scatter) layer: parameter
// defaults, FSM state encoding and the index range helper.
package decomp_layer_pkg;

  localparam int N_DEF        = 10;   // rows (positions)
  localparam int CHAR_NUM_DEF = 200;  // slots per row
  localparam int N_LEN_DEF    = 16;   // bits per value
  localparam int CHAR_LEN_DEF = 8;    // bits per index

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Unsigned compare of an index against the row width.
  function automatic bit idx_out_of_range(input int unsigned idx,
                                          input int unsigned char_num);
    return idx >= char_num;
  endfunction

endpackage

// File: rtl/decomp_layer_if.sv
// Job interface of the decompression layer: run/valid handshake,
// packed per-row indices and values in, scattered flat vector out.
interface decomp_layer_if
  import decomp_layer_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int CHAR_NUM = CHAR_NUM_DEF,
  parameter int N_LEN    = N_LEN_DEF,
  parameter int CHAR_LEN = CHAR_LEN_DEF
) ();

  logic                           run;
  logic [N*CHAR_LEN-1:0]          num;
  logic [N*N_LEN-1:0]             q;
  logic                           valid;
  logic                           err;
  logic [N*CHAR_NUM*N_LEN-1:0]    d;

  modport master (
    output run, num, q,
    input  valid, err, d
  );

  modport slave (
    input  run, num, q,
    output valid, err, d
  );

endinterface

// File: rtl/decomp_layer_onehot_scatter_row.sv
// Combinational one-hot placement of a single value into a CHAR_NUM-slot
// row. Out-of-range indices flag out_of_range; with DECOMP_CLAMP_EN defined
// the value lands in the last slot, otherwise the row stays all zero.
module onehot_scatter_row
  import decomp_layer_pkg::*;
#(
  parameter int CHAR_NUM = CHAR_NUM_DEF,
  parameter int N_LEN    = N_LEN_DEF,
  parameter int CHAR_LEN = CHAR_LEN_DEF
) (
  input  logic [CHAR_LEN-1:0]       index,
  input  logic [N_LEN-1:0]          value,
  output logic [CHAR_NUM*N_LEN-1:0] row,
  output logic                      out_of_range
);

  // Decode the index into a single populated slot; everything else is zero.
  always_comb begin
    row          = '0;
    out_of_range = idx_out_of_range(32'(index), CHAR_NUM);
    for (int j = 0; j < CHAR_NUM; j++) begin
      if (index == CHAR_LEN'(j)) row[j*N_LEN +: N_LEN] = value;
    end
`ifdef DECOMP_CLAMP_EN
    if (out_of_range) row[(CHAR_NUM-1)*N_LEN +: N_LEN] = value;
`endif
  end

endmodule

// File: rtl/decomp_layer.sv
// Decompression layer: inverse of the argmax stage. Latches N indices and
// values on run, then scatters one row per cycle into the flat result d.
// Optional build macro: DECOMP_CLAMP_EN (clamp out-of-range indices to the
// last slot instead of producing an all-zero row).
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for run after reset; d, err, valid are zero
//   SCATTER | writing row[cnt] each cycle from the latched inputs
//   DONE    | result complete, valid high from the second DONE cycle on;
//           | run restarts a fresh job
module decomp_layer
  import decomp_layer_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int CHAR_NUM = CHAR_NUM_DEF,
  parameter int N_LEN    = N_LEN_DEF,
  parameter int CHAR_LEN = CHAR_LEN_DEF
) (
  input logic           clk,
  input logic           rst,
  decomp_layer_if.slave bus
);

  localparam int ROW_W = CHAR_NUM * N_LEN;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [N*CHAR_LEN-1:0]       num_lat;
  logic [N*N_LEN-1:0]          q_lat;
  logic [N*ROW_W-1:0]          d_r;
  logic                        valid_r;
  logic                        err_r;

  logic [CHAR_LEN-1:0]         cur_idx;
  logic [N_LEN-1:0]            cur_val;
  logic [ROW_W-1:0]            cur_row;
  logic                        cur_oor;

  // A single scatter unit serves every row; the counter selects its operands.
  assign cur_idx = num_lat[int'(cnt)*CHAR_LEN +: CHAR_LEN];
  assign cur_val = q_lat[int'(cnt)*N_LEN +: N_LEN];

  onehot_scatter_row #(
    .CHAR_NUM (CHAR_NUM),
    .N_LEN    (N_LEN),
    .CHAR_LEN (CHAR_LEN)
  ) u_row (
    .index        (cur_idx),
    .value        (cur_val),
    .row          (cur_row),
    .out_of_range (cur_oor)
  );

  // Job FSM: start/restart, per-row write into d, sticky error, valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      num_lat <= '0;
      q_lat   <= '0;
      d_r     <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else if (bus.run && state != SCATTER) begin
      // run is honoured from IDLE and DONE alike; valid drops on this edge
      state   <= SCATTER;
      cnt     <= '0;
      num_lat <= bus.num;
      q_lat   <= bus.q;
      d_r     <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_r <= 1'b0;
        end
        SCATTER: begin
          d_r[int'(cnt)*ROW_W +: ROW_W] <= cur_row;
          err_r <= err_r | cur_oor;
          if (cnt == CNT_W'(N-1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          valid_r <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d     = d_r;
  assign bus.valid = valid_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_decomp_layer.sv
// Self-checking bench for decomp_layer: directed and random jobs compared
// against a slot-array reference model of the scatter rules.
module tb_decomp_layer;
  import decomp_layer_pkg::*;

  localparam int N     = N_DEF;
  localparam int CN    = CHAR_NUM_DEF;
  localparam int NL    = N_LEN_DEF;
  localparam int CL    = CHAR_LEN_DEF;
  localparam int ROW_W = CN * NL;

  logic clk = 1'b0;
  logic rst;

  decomp_layer_if bus ();

  decomp_layer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned       idx_in  [N];
  logic [NL-1:0]     val_in  [N];
  logic [NL-1:0]     exp_slot[N][CN];
  logic              exp_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.num[i*CL +: CL] = CL'(idx_in[i]);
      bus.q[i*NL +: NL]   = val_in[i];
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      bus.num[i*CL +: CL] = CL'($urandom_range(0, 255));
      bus.q[i*NL +: NL]   = NL'($urandom);
    end
  endtask

  // Reference: each row holds its value at its index, zero elsewhere.
  task automatic build_model();
    exp_err = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < CN; j++)
        exp_slot[i][j] = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_in[i] < CN) begin
        exp_slot[i][idx_in[i]] = val_in[i];
      end else begin
        exp_err = 1'b1;
`ifdef DECOMP_CLAMP_EN
        exp_slot[i][CN-1] = val_in[i];
`endif
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag);
    logic [ROW_W-1:0] exp_row;
    logic [ROW_W-1:0] got_row;
    int               first;
    chk({tag, " err"}, 64'(bus.err), 64'(exp_err));
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < CN; j++) exp_row[j*NL +: NL] = exp_slot[i][j];
      got_row = bus.d[i*ROW_W +: ROW_W];
      n_assert++;
      assert (got_row === exp_row) else begin
        n_fail++;
        first = -1;
        for (int j = CN - 1; j >= 0; j--)
          if (got_row[j*NL +: NL] !== exp_row[j*NL +: NL]) first = j;
        $error("FAIL %s row%0d: slot %0d got %0h expected %0h", tag, i, first,
               got_row[first*NL +: NL], exp_row[first*NL +: NL]);
      end
    end
  endtask

  // Start a job from idx_in/val_in, optionally pulse run again at SCATTER
  // cycle mid_run_at and/or churn the inputs, then check timing and data.
  task automatic run_job(input string tag, input int mid_run_at, input bit churn);
    drive_inputs();
    build_model();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    chk({tag, " valid_drop"}, 64'(bus.valid), 64'd0);
    for (int j = 1; j <= N + 1; j++) begin
      if (j == mid_run_at) bus.run = 1'b1;
      if (churn) scramble_inputs();
      tick();
      bus.run = 1'b0;
      if (j == N)     chk({tag, " valid_early"}, 64'(bus.valid), 64'd0);
      if (j == N + 1) chk({tag, " valid_rise"},  64'(bus.valid), 64'd1);
    end
    check_result(tag);
  endtask

  task automatic rand_legal();
    for (int i = 0; i < N; i++) begin
      idx_in[i] = $urandom_range(0, CN - 1);
      val_in[i] = NL'($urandom);
    end
  endtask

  initial begin
    rst     = 1'b1;
    bus.run = 1'b0;
    bus.num = '0;
    bus.q   = '0;
    tick();
    tick();
    chk("reset valid", 64'(bus.valid), 64'd0);
    chk("reset err",   64'(bus.err),   64'd0);
    n_assert++;
    assert (bus.d === '0) else begin
      n_fail++;
      $error("FAIL reset d: %0d bits set, expected 0", $countones(bus.d));
    end
    rst = 1'b0;
    tick();

    for (int i = 0; i < N; i++) begin
      idx_in[i] = i * 20;
      val_in[i] = NL'(16'h0100 + i);
    end
    run_job("basic", 0, 1'b0);

    scramble_inputs();
    tick(); tick(); tick();
    chk("hold valid", 64'(bus.valid), 64'd1);
    check_result("hold");

    rand_legal();
    idx_in[0] = 0;
    idx_in[N-1] = CN - 1;
    for (int i = 0; i < N; i++) val_in[i] = 16'hFFFF;
    run_job("boundary", 0, 1'b0);

    rand_legal();
    idx_in[3] = CN;
    val_in[3] = 16'hBEEF;
    run_job("oor", 0, 1'b0);

    rand_legal();
    run_job("midrun", 4, 1'b0);

    rand_legal();
    run_job("churn", 0, 1'b1);

    rand_legal();
    idx_in[0] = 255;
    drive_inputs();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst valid", 64'(bus.valid), 64'd0);
    chk("midrst err",   64'(bus.err),   64'd0);
    n_assert++;
    assert (bus.d === '0) else begin
      n_fail++;
      $error("FAIL midrst d: %0d bits set, expected 0", $countones(bus.d));
    end
    rst = 1'b0;
    for (int j = 0; j < N + 3; j++) tick();
    chk("midrst idle", 64'(bus.valid), 64'd0);

    rand_legal();
    run_job("after_rst", 0, 1'b0);

    rand_legal();
    for (int i = 0; i < N; i++) val_in[i] = '0;
    run_job("zero", 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rand_legal();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) idx_in[i] = $urandom_range(CN, 255);
      run_job($sformatf("rand%0d", r), 0, 1'(r % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
